motion_ctrl: RTL

MOTION_CTRL -- requirements
Module: motion_ctrl

---
 rtl/motion_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/motion_ctrl.sv
// Sprite motion controller: frame handshake FSM (IDLE/ERASE/MOVE/DRAW) driving a
// ground/rise/fall motion model. Define MOTION_OVERRUN_EN to enable sticky tick-drop reporting.
module motion_ctrl #(
    parameter int X_MAX       = 155,
    parameter int Y_FLOOR     = 115,
    parameter int JUMP_HEIGHT = 30,
    parameter int SPEED_DIV   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    input  logic       erase_done,
    input  logic       draw_done,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       erase_req,
    output logic       draw_req,
    output logic       busy,
    output logic       on_ground,
    output logic       overrun
);

    localparam int                FCNT_W    = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SPEED_DIV - 1);
    localparam logic [7:0]        X_LIM     = 8'(X_MAX);
    localparam logic [7:0]        Y_GND     = 8'(Y_FLOOR);
    localparam logic [7:0]        JCNT_LAST = 8'(JUMP_HEIGHT - 1);

    typedef enum logic [1:0] {
        F_IDLE,
        F_ERASE,
        F_MOVE,
        F_DRAW
    } frame_state_e;

    typedef enum logic [1:0] {
        M_GROUND,
        M_RISE,
        M_FALL
    } motion_state_e;

    frame_state_e      frame_q, frame_d;
    motion_state_e     motion_q, motion_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        jcnt_q, jcnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              pending_q, pending_d;
    logic [8:0]        y_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q   <= F_IDLE;
            motion_q  <= M_GROUND;
            x_q       <= 8'd0;
            y_q       <= Y_GND;
            jcnt_q    <= 8'd0;
            fcnt_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            motion_q  <= motion_d;
            x_q       <= x_d;
            y_q       <= y_d;
            jcnt_q    <= jcnt_d;
            fcnt_q    <= fcnt_d;
            pending_q <= pending_d;
        end
    end

    // Frame sequencing; a tick arriving while busy is remembered once.
    always_comb begin
        frame_d   = frame_q;
        pending_d = pending_q;
        case (frame_q)
            F_IDLE: begin
                if (frame_tick || pending_q) begin
                    frame_d   = F_ERASE;
                    pending_d = 1'b0;
                end
            end
            F_ERASE: if (erase_done) frame_d = F_MOVE;
            F_MOVE:  frame_d = F_DRAW;
            F_DRAW:  if (draw_done) frame_d = F_IDLE;
            default: frame_d = F_IDLE;
        endcase
        if (frame_q != F_IDLE && frame_tick && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    // Position and motion update, only during the single MOVE cycle.
    always_comb begin
        motion_d = motion_q;
        x_d      = x_q;
        y_d      = y_q;
        jcnt_d   = jcnt_q;
        fcnt_d   = fcnt_q;
        y_inc    = {1'b0, y_q} + 9'd1;
        if (frame_q == F_MOVE) begin
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
            if (fcnt_q == FCNT_LAST) begin
                if (right && !left && x_q < X_LIM) begin
                    x_d = x_q + 8'd1;
                end else if (left && !right && x_q != 8'd0) begin
                    x_d = x_q - 8'd1;
                end
            end
            case (motion_q)
                M_GROUND: begin
                    if (jump) begin
                        motion_d = M_RISE;
                        jcnt_d   = 8'd0;
                        if (y_q != 8'd0) y_d = y_q - 8'd1;
                    end
                end
                M_RISE: begin
                    jcnt_d = jcnt_q + 8'd1;
                    if (y_q != 8'd0) y_d = y_q - 8'd1;
                    // Apex reached by jump length or by hitting the top edge.
                    if (jcnt_q + 8'd1 >= JCNT_LAST || y_q <= 8'd1) begin
                        motion_d = M_FALL;
                    end
                end
                M_FALL: begin
                    if (y_q < Y_GND) y_d = y_q + 8'd1;
                    if (y_inc >= {1'b0, Y_GND}) motion_d = M_GROUND;
                end
                default: motion_d = M_GROUND;
            endcase
        end
    end

`ifdef MOTION_OVERRUN_EN
    logic overrun_q;
    logic tick_dropped;

    assign tick_dropped = frame_tick && (frame_q != F_IDLE) && pending_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (tick_dropped) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign x         = x_q;
    assign y         = y_q;
    assign erase_req = (frame_q == F_ERASE);
    assign draw_req  = (frame_q == F_DRAW);
    assign busy      = (frame_q != F_IDLE);
    assign on_ground = (motion_q == M_GROUND);

endmodule
